// File: rtl/instruction_fetch_unit.sv
// Fetch responder: owns PC/IR, fetches one word per PC over REQ/ACK, decodes IR fields.
// IF_DONE three cycles after W_IM with a zero-wait memory; waits up to TIMEOUT cycles for IM_ACK.
module instruction_fetch_unit #(
   parameter int unsigned         ADDR_W   = 16,
   parameter int unsigned         DATA_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0,
   parameter int unsigned         TIMEOUT  = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              w_im_i,
   input  logic              w_pc_i,
   input  logic              s_mxpc_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic              im_req_o,
   output logic [ADDR_W-1:0] im_addr_o,
   input  logic              im_ack_i,
   input  logic [DATA_W-1:0] im_data_i,
   output logic              if_done_o,
   output logic              if_err_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [2:0]        type_o,
   output logic [4:0]        op_o,
   output logic [3:0]        rd_o,
   output logic [3:0]        ra_o,
   output logic [3:0]        rb_o,
   output logic [15:0]       imm_o
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                fetched_q, fetched_d;
   logic                pend_q, pend_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   npc;
   logic                complete;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      ir_d      = ir_q;
      cnt_d     = cnt_q;
      fetched_d = fetched_q;
      pend_d    = pend_q;
      done_d    = 1'b0;
      err_d     = err_q;
      npc       = s_mxpc_i ? target_i : pc_q + ADDR_W'(1);
      complete  = im_ack_i || (cnt_q == CNT_W'(TIMEOUT - 1));

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // A PC write takes priority; the fetch starts from the new PC next cycle.
            if (w_pc_i) begin
               pc_d      = npc;
               fetched_d = 1'b0;
            end else if (w_im_i && !fetched_q) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            cnt_d   = '0;
            state_d = S_WAIT;
            if (w_pc_i) begin
               pend_d    = 1'b1;
               pend_pc_d = npc;
            end
         end
         S_WAIT: begin
            if (!complete) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (w_pc_i) begin
                  pend_d    = 1'b1;
                  pend_pc_d = npc;
               end
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               cnt_d   = '0;
               pend_d  = 1'b0;
               ir_d    = im_ack_i ? im_data_i : '0;
               if (!im_ack_i) err_d = 1'b1;
               // A PC write in the completion cycle beats any earlier pending write.
               if (w_pc_i) begin
                  pc_d      = npc;
                  fetched_d = 1'b0;
               end else if (pend_q) begin
                  pc_d      = pend_pc_q;
                  fetched_d = 1'b0;
               end else begin
                  fetched_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         pend_pc_q <= '0;
         ir_q      <= '0;
         cnt_q     <= '0;
         fetched_q <= 1'b0;
         pend_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         ir_q      <= ir_d;
         cnt_q     <= cnt_d;
         fetched_q <= fetched_d;
         pend_q    <= pend_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign im_req_o  = (state_q != S_IDLE);
   assign im_addr_o = pc_q;
   assign if_done_o = done_q;
   assign if_err_o  = err_q;
   assign pc_o      = pc_q;
   assign type_o    = ir_q[31:29];
   assign op_o      = ir_q[28:24];
   assign rd_o      = ir_q[23:20];
   assign ra_o      = ir_q[19:16];
   assign rb_o      = ir_q[15:12];
   assign imm_o     = ir_q[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: scripted scenarios, a variable-latency memory responder
// and a scoreboard of expected instruction words checked on every IF_DONE.
module tb_instruction_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        w_im_i, w_pc_i, s_mxpc_i;
   logic [15:0] target_i;
   logic        im_req_o;
   logic [15:0] im_addr_o;
   logic        im_ack_i;
   logic [31:0] im_data_i;
   logic        if_done_o, if_err_o;
   logic [15:0] pc_o;
   logic [2:0]  type_o;
   logic [4:0]  op_o;
   logic [3:0]  rd_o, ra_o, rb_o;
   logic [15:0] imm_o;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          done_cnt = 0;
   logic [31:0] exp_q[$];

   // responder state
   int          ack_wait = 1;
   int          req_cnt  = 0;
   logic [15:0] req_addr, last_req_addr;
   logic        addr_moved = 1'b0;
   logic        resp_ack = 1'b0, man_ack = 1'b0;
   logic [31:0] resp_dat = '0, man_dat = '0;

   assign im_ack_i  = resp_ack | man_ack;
   assign im_data_i = man_ack ? man_dat : resp_dat;

   always #5 clk_i = ~clk_i;

   instruction_fetch_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .w_im_i(w_im_i), .w_pc_i(w_pc_i),
      .s_mxpc_i(s_mxpc_i), .target_i(target_i), .im_req_o(im_req_o),
      .im_addr_o(im_addr_o), .im_ack_i(im_ack_i), .im_data_i(im_data_i),
      .if_done_o(if_done_o), .if_err_o(if_err_o), .pc_o(pc_o), .type_o(type_o),
      .op_o(op_o), .rd_o(rd_o), .ra_o(ra_o), .rb_o(rb_o), .imm_o(imm_o)
   );

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (a == 16'h0000) return 32'h2A31_5000;
      return {~a, a};
   endfunction

   // Memory: ACK in the ack_wait-th WAIT cycle (0 = never); the REQ cycle is the first req-high cycle.
   always @(negedge clk_i) begin
      if (rst_i || !im_req_o) begin
         req_cnt  = 0;
         resp_ack = 1'b0;
      end else begin
         req_cnt = req_cnt + 1;
         if (req_cnt == 1) begin
            req_addr      = im_addr_o;
            last_req_addr = im_addr_o;
         end else if (im_addr_o !== req_addr) begin
            addr_moved = 1'b1;
         end
         resp_ack = (ack_wait != 0) && (req_cnt == ack_wait + 1);
         resp_dat = mem_word(im_addr_o);
      end
   end

   always @(negedge clk_i) begin
      if (!rst_i && if_done_o === 1'b1) begin
         logic [31:0] exp_w, act_w;
         done_cnt = done_cnt + 1;
         n_checks = n_checks + 1;
         act_w = {type_o, op_o, rd_o, ra_o, imm_o};
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected_done: IR=%h with no fetch expected", act_w);
         end else begin
            exp_w = exp_q.pop_front();
            if (act_w !== exp_w || rb_o !== exp_w[15:12])
               $display("FAIL sb_ir: got %h rb=%h, expected %h", act_w, rb_o, exp_w);
            else
               n_pass = n_pass + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_done(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (if_done_o === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic set_pc(input logic [15:0] t);
      w_pc_i = 1'b1; s_mxpc_i = 1'b1; target_i = t;
      tick();
      w_pc_i = 1'b0; s_mxpc_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; w_im_i = 1'b0; w_pc_i = 1'b0; s_mxpc_i = 1'b0; target_i = '0;
      tick(); tick();
      rst_i = 1'b0;
      n_checks++;
      if (pc_o !== 16'h0000 || im_req_o !== 1'b0) $display("FAIL reset_pc_req: pc=%h req=%b, expected 0000/0", pc_o, im_req_o);
      else n_pass++;
      n_checks++;
      if (if_done_o !== 1'b0 || if_err_o !== 1'b0) $display("FAIL reset_done_err: done=%b err=%b, expected 0/0", if_done_o, if_err_o);
      else n_pass++;
      n_checks++;
      if ({type_o, op_o, rd_o, ra_o, imm_o} !== 32'h0) $display("FAIL reset_ir: got %h, expected 0", {type_o, op_o, rd_o, ra_o, imm_o});
      else n_pass++;
   endtask

   task automatic test_fetch_basic();
      int  n;
      logic any_req;
      ack_wait = 1;
      exp_q.push_back(32'h2A31_5000);
      w_im_i = 1'b1;
      wait_done(10, n);
      n_checks++;
      if (n != 3) $display("FAIL fetch_latency: IF_DONE after %0d cycles, expected 3", n);
      else n_pass++;
      n_checks++;
      if (last_req_addr !== 16'h0000) $display("FAIL fetch_addr: %h, expected 0000", last_req_addr);
      else n_pass++;
      n_checks++;
      if (type_o !== 3'd1 || op_o !== 5'h0A || rd_o !== 4'd3 || ra_o !== 4'd1 || rb_o !== 4'd5 || imm_o !== 16'h5000)
         $display("FAIL decode: type=%h op=%h rd=%h ra=%h rb=%h imm=%h, expected 1/0a/3/1/5/5000",
                  type_o, op_o, rd_o, ra_o, rb_o, imm_o);
      else n_pass++;
      any_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         any_req |= im_req_o;
      end
      n_checks++;
      if (any_req !== 1'b0) $display("FAIL single_fetch: req=%b while fetched, expected 0", any_req);
      else n_pass++;
      w_im_i = 1'b0;
   endtask

   task automatic test_pc_increment();
      int n;
      set_pc(16'h0004);
      n_checks++;
      if (pc_o !== 16'h0004) $display("FAIL pc_load: %h, expected 0004", pc_o);
      else n_pass++;
      exp_q.push_back(mem_word(16'h0004));
      w_im_i = 1'b1;
      wait_done(10, n);
      w_pc_i = 1'b1; s_mxpc_i = 1'b0;
      tick();
      w_pc_i = 1'b0;
      n_checks++;
      if (pc_o !== 16'h0005) $display("FAIL pc_inc: %h, expected 0005", pc_o);
      else n_pass++;
      exp_q.push_back(mem_word(16'h0005));
      wait_done(10, n);
      n_checks++;
      if (n != 3 || last_req_addr !== 16'h0005) $display("FAIL refetch: n=%0d addr=%h, expected 3/0005", n, last_req_addr);
      else n_pass++;
      w_im_i = 1'b0;
   endtask

   task automatic test_pc_wrap();
      int n;
      set_pc(16'hFFFF);
      w_pc_i = 1'b1; s_mxpc_i = 1'b0;
      tick();
      w_pc_i = 1'b0;
      n_checks++;
      if (pc_o !== 16'h0000) $display("FAIL pc_wrap: %h, expected 0000", pc_o);
      else n_pass++;
      set_pc(16'h1234);
      n_checks++;
      if (pc_o !== 16'h1234) $display("FAIL pc_target: %h, expected 1234", pc_o);
      else n_pass++;
      // W_IM and W_PC together in IDLE: PC update only, fetch next cycle.
      w_im_i = 1'b1; w_pc_i = 1'b1; s_mxpc_i = 1'b1; target_i = 16'h0040;
      tick();
      w_pc_i = 1'b0; s_mxpc_i = 1'b0;
      n_checks++;
      if (im_req_o !== 1'b0 || pc_o !== 16'h0040) $display("FAIL wim_wpc: req=%b pc=%h, expected 0/0040", im_req_o, pc_o);
      else n_pass++;
      exp_q.push_back(mem_word(16'h0040));
      wait_done(10, n);
      n_checks++;
      if (n != 3 || last_req_addr !== 16'h0040) $display("FAIL wim_wpc_fetch: n=%0d addr=%h, expected 3/0040", n, last_req_addr);
      else n_pass++;
      w_im_i = 1'b0;
   endtask

   task automatic test_pending_pc();
      int n;
      set_pc(16'h0010);
      ack_wait   = 6;
      addr_moved = 1'b0;
      exp_q.push_back(mem_word(16'h0010));
      w_im_i = 1'b1;
      tick(); tick(); tick();
      w_pc_i = 1'b1; s_mxpc_i = 1'b1; target_i = 16'h0100;
      tick();
      w_pc_i = 1'b0; s_mxpc_i = 1'b0;
      n_checks++;
      if (pc_o !== 16'h0010 || im_addr_o !== 16'h0010) $display("FAIL pend_hold: pc=%h addr=%h, expected 0010/0010", pc_o, im_addr_o);
      else n_pass++;
      wait_done(20, n);
      n_checks++;
      if (n != 4 || pc_o !== 16'h0100) $display("FAIL pend_apply: n=%0d pc=%h, expected 4/0100", n, pc_o);
      else n_pass++;
      n_checks++;
      if (addr_moved !== 1'b0) $display("FAIL addr_stable: moved=%b, expected 0", addr_moved);
      else n_pass++;
      ack_wait = 1;
      exp_q.push_back(mem_word(16'h0100));
      wait_done(10, n);
      n_checks++;
      if (n != 3 || last_req_addr !== 16'h0100) $display("FAIL pend_refetch: n=%0d addr=%h, expected 3/0100", n, last_req_addr);
      else n_pass++;
      w_im_i = 1'b0;
   endtask

   task automatic test_ack_wpc_same_cycle();
      set_pc(16'h0180);
      ack_wait = 1;
      exp_q.push_back(mem_word(16'h0180));
      w_im_i = 1'b1;
      tick(); tick();
      w_im_i = 1'b0; w_pc_i = 1'b1; s_mxpc_i = 1'b1; target_i = 16'h0200;
      tick();
      w_pc_i = 1'b0; s_mxpc_i = 1'b0;
      n_checks++;
      if (if_done_o !== 1'b1 || pc_o !== 16'h0200) $display("FAIL ack_wpc: done=%b pc=%h, expected 1/0200", if_done_o, pc_o);
      else n_pass++;
      tick();
   endtask

   task automatic test_timeout();
      int n;
      set_pc(16'h0020);
      ack_wait = 0;
      exp_q.push_back(32'h0);
      w_im_i = 1'b1;
      wait_done(40, n);
      w_im_i = 1'b0;
      n_checks++;
      if (n != 17) $display("FAIL timeout_latency: IF_DONE after %0d cycles, expected 17", n);
      else n_pass++;
      n_checks++;
      if (if_err_o !== 1'b1 || imm_o !== 16'h0 || type_o !== 3'd0) $display("FAIL timeout_err: err=%b imm=%h type=%h, expected 1/0000/0", if_err_o, imm_o, type_o);
      else n_pass++;
      set_pc(16'h0300);
      ack_wait = 1;
      exp_q.push_back(mem_word(16'h0300));
      w_im_i = 1'b1;
      wait_done(10, n);
      w_im_i = 1'b0;
      tick(); tick();
      n_checks++;
      if (if_err_o !== 1'b1) $display("FAIL err_sticky: err=%b, expected 1", if_err_o);
      else n_pass++;
   endtask

   task automatic test_reset_midfetch();
      int d0;
      ack_wait = 0;
      w_im_i = 1'b1;
      tick(); tick(); tick(); tick();
      rst_i = 1'b1; w_im_i = 1'b0;
      tick();
      rst_i = 1'b0;
      d0 = done_cnt;
      n_checks++;
      if (im_req_o !== 1'b0) $display("FAIL rst_req_drop: req=%b, expected 0", im_req_o);
      else n_pass++;
      man_ack = 1'b1; man_dat = 32'hDEAD_BEEF;
      tick();
      man_ack = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if (pc_o !== 16'h0000 || {type_o, op_o, rd_o, ra_o, imm_o} !== 32'h0 || if_err_o !== 1'b0)
         $display("FAIL rst_state: pc=%h ir=%h err=%b, expected 0000/0/0", pc_o, {type_o, op_o, rd_o, ra_o, imm_o}, if_err_o);
      else n_pass++;
      n_checks++;
      if (done_cnt != d0 || im_req_o !== 1'b0) $display("FAIL rst_late_ack: done pulses=%0d req=%b, expected 0/0", done_cnt - d0, im_req_o);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fetch_basic();
      test_pc_increment();
      test_pc_wrap();
      test_pending_pc();
      test_ack_wpc_same_cycle();
      test_timeout();
      test_reset_midfetch();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL sb_leftover: %0d fetches never completed, expected 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
